xc30xx_clb: RTL and testbench

- Parametrised successor CLB for the xc20xx-family architecture model.
- Two function generators of LUT_K inputs each, with optional combination into one (LUT_K+1)-input function.
- Two storage elements, each configurable as flip-flop or latch, with clock enable, synchronous local set/reset and optional register feedback into the LUTs.
- Sits in the primitives/clb tree as the CLB used by the routing graph and techmap of the next device family.

---
 rtl/xc30xx_clb_pkg.sv | 49 ++++
 rtl/xc30xx_clb_se.sv | 58 +++++
 rtl/xc30xx_clb.sv | 158 +++++++++++++++
 tb/tb_xc30xx_clb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xc30xx_clb_pkg.sv
// Shared encodings and parameter-string decoders for the xc30xx CLB.
// Parameter strings are carried as 64-bit packed vectors, which is wide
// enough for the longest legal value ("POSITIVE" / "NEGATIVE").
package xc30xx_clb_pkg;

    localparam int STR_W = 64;
    typedef logic [STR_W-1:0] pstr_t;

    typedef enum logic [1:0] {FB_NONE, FB_QX, FB_QY} fb_e;
    typedef enum logic [1:0] {D_F, D_G, D_DI} dsrc_e;
    typedef enum logic [1:0] {OUT_F, OUT_G, OUT_QX, OUT_QY} out_e;
    typedef enum logic {MODE_DFF, MODE_DLATCH} mode_e;
    typedef enum logic {POL_POS, POL_NEG} pol_e;

    // LUT input-0 source; anything unrecognised means plain IN[0]
    function automatic fb_e fb_enc(input pstr_t s);
        if (s == pstr_t'("QX")) return FB_QX;
        if (s == pstr_t'("QY")) return FB_QY;
        return FB_NONE;
    endfunction

    // Storage data source; unknown strings take the caller's default
    function automatic dsrc_e dsrc_enc(input pstr_t s, input dsrc_e dflt);
        if (s == pstr_t'("F"))  return D_F;
        if (s == pstr_t'("G"))  return D_G;
        if (s == pstr_t'("DI")) return D_DI;
        return dflt;
    endfunction

    // Output select; unknown strings fall back to the caller's default
    function automatic out_e out_enc(input pstr_t s, input out_e dflt);
        if (s == pstr_t'("F"))  return OUT_F;
        if (s == pstr_t'("G"))  return OUT_G;
        if (s == pstr_t'("QX")) return OUT_QX;
        if (s == pstr_t'("QY")) return OUT_QY;
        return dflt;
    endfunction

    function automatic mode_e mode_enc(input pstr_t s);
        if (s == pstr_t'("DLATCH")) return MODE_DLATCH;
        return MODE_DFF;
    endfunction

    function automatic pol_e pol_enc(input pstr_t s);
        if (s == pstr_t'("NEGATIVE")) return POL_NEG;
        return POL_POS;
    endfunction

endpackage

// File: rtl/xc30xx_clb_se.sv
// One CLB storage element: edge flip-flop or level latch, with shared
// clock enable, synchronous set/reset value and asynchronous init.
module xc30xx_clb_se
    import xc30xx_clb_pkg::*;
#(
    parameter mode_e MODE    = MODE_DFF,
    parameter pol_e  CLK_POL = POL_POS,
    parameter logic  INIT    = 1'b0,
    parameter logic  SR_VAL  = 1'b0
)(
    input  logic K,
    input  logic RST_N,
    input  logic D,
    input  logic EC,
    input  logic SR,
    output logic Q
);

    logic k_act;
    logic q_q;

    // Fold clock polarity into one internal active-high clock/level
    assign k_act = (CLK_POL == POL_NEG) ? ~K : K;

    generate
        if (MODE == MODE_DLATCH) begin : g_latch
            // Transparent while active level and EC; SR overrides D while open
            always_latch begin
                if (!RST_N)
                    q_q <= INIT;
                else if (k_act && EC)
                    q_q <= SR ? SR_VAL : D;
            end
        end else begin : g_dff
            logic q_d;

            // Capture value: SR wins over EC, otherwise hold
            always_comb begin
                q_d = q_q;
                if (SR)
                    q_d = SR_VAL;
                else if (EC)
                    q_d = D;
            end

            // Edge register with asynchronous init
            always_ff @(posedge k_act or negedge RST_N) begin
                if (!RST_N)
                    q_q <= INIT;
                else
                    q_q <= q_d;
            end
        end
    endgenerate

    assign Q = q_q;

endmodule

// File: rtl/xc30xx_clb.sv
// xc30xx configurable logic block: two LUT_K-input function generators
// (optionally merged into one LUT_K+1 function), two storage elements with
// optional register feedback into LUT input 0, and two output selects.
module xc30xx_clb
    import xc30xx_clb_pkg::*;
#(
    parameter int                  LUT_K      = 4,
    parameter logic [2**LUT_K-1:0] F_INIT     = '0,
    parameter logic [2**LUT_K-1:0] G_INIT     = '0,
    parameter bit                  COMBINE_FG = 1'b0,
    parameter pstr_t               F_FB       = "NONE",
    parameter pstr_t               G_FB       = "NONE",
    parameter pstr_t               QX_D       = "F",
    parameter pstr_t               QY_D       = "G",
    parameter pstr_t               MODE_X     = "DFF",
    parameter pstr_t               MODE_Y     = "DFF",
    parameter pstr_t               CLK_POL    = "POSITIVE",
    parameter logic                QX_INIT    = 1'b0,
    parameter logic                QY_INIT    = 1'b0,
    parameter logic                SR_VAL_X   = 1'b0,
    parameter logic                SR_VAL_Y   = 1'b0,
    parameter pstr_t               X_OUT      = "F",
    parameter pstr_t               Y_OUT      = "QY"
)(
    input  logic           K,
    input  logic           RST_N,
    input  logic [LUT_K:0] IN,
    input  logic           DI,
    input  logic           EC,
    input  logic           SR,
    output logic           X,
    output logic           Y
);

    localparam fb_e   F_FB_E   = fb_enc(F_FB);
    localparam fb_e   G_FB_E   = fb_enc(G_FB);
    localparam dsrc_e QX_D_E   = dsrc_enc(QX_D, D_F);
    localparam dsrc_e QY_D_E   = dsrc_enc(QY_D, D_G);
    localparam mode_e MODE_X_E = mode_enc(MODE_X);
    localparam mode_e MODE_Y_E = mode_enc(MODE_Y);
    localparam pol_e  POL_E    = pol_enc(CLK_POL);
    localparam out_e  X_OUT_E  = out_enc(X_OUT, OUT_F);
    localparam out_e  Y_OUT_E  = out_enc(Y_OUT, OUT_QY);

    // Configuration sanity: LUT size, and no feedback through an open latch
    generate
        if (LUT_K < 3 || LUT_K > 5) begin : g_bad_k
            $error("xc30xx_clb: LUT_K=%0d outside legal range 3..5", LUT_K);
        end
        if ((F_FB_E == FB_QX || G_FB_E == FB_QX) && MODE_X_E == MODE_DLATCH) begin : g_bad_fbx
            $error("xc30xx_clb: feedback from QX while QX is a latch forms a combinational loop");
        end
        if ((F_FB_E == FB_QY || G_FB_E == FB_QY) && MODE_Y_E == MODE_DLATCH) begin : g_bad_fby
            $error("xc30xx_clb: feedback from QY while QY is a latch forms a combinational loop");
        end
    endgenerate

    logic             qx_q, qy_q;
    logic             qx_d, qy_d;
    logic             f_in0, g_in0;
    logic [LUT_K-1:0] f_idx, g_idx;
    logic             f_lut, g_lut;
    logic             f_fn, g_fn;

    // Input-0 muxes are resolved at elaboration so unused feedback paths
    // never exist in the netlist (keeps latch configurations loop-free).
    generate
        if (F_FB_E == FB_QX) begin : g_ffb_qx
            assign f_in0 = qx_q;
        end else if (F_FB_E == FB_QY) begin : g_ffb_qy
            assign f_in0 = qy_q;
        end else begin : g_ffb_in
            assign f_in0 = IN[0];
        end

        if (G_FB_E == FB_QX) begin : g_gfb_qx
            assign g_in0 = qx_q;
        end else if (G_FB_E == FB_QY) begin : g_gfb_qy
            assign g_in0 = qy_q;
        end else begin : g_gfb_in
            assign g_in0 = IN[0];
        end
    endgenerate

    // Truth-table lookup; in combine mode IN[LUT_K] picks G over F for both
    always_comb begin
        f_idx = {IN[LUT_K-1:1], f_in0};
        g_idx = {IN[LUT_K-1:1], g_in0};
        f_lut = F_INIT[f_idx];
        g_lut = G_INIT[g_idx];
        if (COMBINE_FG) begin
            f_fn = IN[LUT_K] ? g_lut : f_lut;
            g_fn = f_fn;
        end else begin
            f_fn = f_lut;
            g_fn = g_lut;
        end
    end

    // Storage data source selection
    always_comb begin
        case (QX_D_E)
            D_G:     qx_d = g_fn;
            D_DI:    qx_d = DI;
            default: qx_d = f_fn;
        endcase
        case (QY_D_E)
            D_F:     qy_d = f_fn;
            D_DI:    qy_d = DI;
            default: qy_d = g_fn;
        endcase
    end

    xc30xx_clb_se #(
        .MODE    (MODE_X_E),
        .CLK_POL (POL_E),
        .INIT    (QX_INIT),
        .SR_VAL  (SR_VAL_X)
    ) u_se_x (
        .K     (K),
        .RST_N (RST_N),
        .D     (qx_d),
        .EC    (EC),
        .SR    (SR),
        .Q     (qx_q)
    );

    xc30xx_clb_se #(
        .MODE    (MODE_Y_E),
        .CLK_POL (POL_E),
        .INIT    (QY_INIT),
        .SR_VAL  (SR_VAL_Y)
    ) u_se_y (
        .K     (K),
        .RST_N (RST_N),
        .D     (qy_d),
        .EC    (EC),
        .SR    (SR),
        .Q     (qy_q)
    );

    // Output selects (decoder already applied the fallbacks)
    always_comb begin
        case (X_OUT_E)
            OUT_G:   X = g_fn;
            OUT_QX:  X = qx_q;
            OUT_QY:  X = qy_q;
            default: X = f_fn;
        endcase
        case (Y_OUT_E)
            OUT_F:   Y = f_fn;
            OUT_G:   Y = g_fn;
            OUT_QX:  Y = qx_q;
            default: Y = qy_q;
        endcase
    end

endmodule

// File: tb/tb_xc30xx_clb.sv
// Bench for xc30xx_clb: six differently configured CLBs share one set of
// inputs; a behavioural model tracks all of them and is compared on every
// input or clock event, plus directed checks with hand-derived values.
`timescale 1ns/100ps
module tb_xc30xx_clb;

    logic       K = 1'b0;
    logic       RST_N = 1'b1;
    logic [4:0] IN = '0;
    logic       DI = 1'b0;
    logic       EC = 1'b0;
    logic       SR = 1'b0;
    logic [5:0] xo, yo;

    int n_chk = 0;
    int n_fail = 0;

    // out/data codes: 0=F 1=G 2=QX/DI 3=QY ; fb codes: 0=IN0 1=QX 2=QY
    typedef struct {
        logic [15:0] finit;
        logic [15:0] ginit;
        int comb, ffb, gfb, qxd, qyd, latx, laty, neg, qxi, qyi, srx, sry, xsel, ysel;
    } cfg_t;

    cfg_t cfg [6] = '{
        '{16'h8000, 16'h0001, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0, 3},
        '{16'h8000, 16'h0001, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 1, 2, 1},
        '{16'h8000, 16'h0001, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1},
        '{16'h5555, 16'h0000, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 2, 3},
        '{16'h0000, 16'h0000, 0, 0, 0, 2, 2, 0, 0, 1, 0, 0, 1, 0, 2, 3},
        '{16'h0000, 16'h0000, 0, 0, 0, 2, 2, 1, 0, 0, 0, 1, 0, 0, 2, 3}
    };

    logic mq [6][2];
    logic kp = 1'b0;

    xc30xx_clb #(.LUT_K(4), .F_INIT(16'h8000), .G_INIT(16'h0001), .QX_D("DI"), .QY_D("G"),
                 .QX_INIT(1'b1), .SR_VAL_Y(1'b1), .X_OUT("F"), .Y_OUT("QY"))
        u_a (.K(K), .RST_N(RST_N), .IN(IN), .DI(DI), .EC(EC), .SR(SR), .X(xo[0]), .Y(yo[0]));
    xc30xx_clb #(.LUT_K(4), .F_INIT(16'h8000), .G_INIT(16'h0001), .QX_D("DI"), .QY_D("G"),
                 .QX_INIT(1'b1), .SR_VAL_Y(1'b1), .X_OUT("QX"), .Y_OUT("G"))
        u_b (.K(K), .RST_N(RST_N), .IN(IN), .DI(DI), .EC(EC), .SR(SR), .X(xo[1]), .Y(yo[1]));
    xc30xx_clb #(.LUT_K(4), .F_INIT(16'h8000), .G_INIT(16'h0001), .COMBINE_FG(1'b1),
                 .X_OUT("F"), .Y_OUT("G"))
        u_c (.K(K), .RST_N(RST_N), .IN(IN), .DI(DI), .EC(EC), .SR(SR), .X(xo[2]), .Y(yo[2]));
    xc30xx_clb #(.LUT_K(4), .F_INIT(16'h5555), .F_FB("QX"), .QX_D("F"), .QY_D("DI"),
                 .X_OUT("QX"), .Y_OUT("QY"))
        u_d (.K(K), .RST_N(RST_N), .IN(IN), .DI(DI), .EC(EC), .SR(SR), .X(xo[3]), .Y(yo[3]));
    xc30xx_clb #(.LUT_K(4), .CLK_POL("NEGATIVE"), .QX_D("DI"), .QY_D("DI"), .SR_VAL_X(1'b1),
                 .X_OUT("QX"), .Y_OUT("QY"))
        u_e (.K(K), .RST_N(RST_N), .IN(IN), .DI(DI), .EC(EC), .SR(SR), .X(xo[4]), .Y(yo[4]));
    xc30xx_clb #(.LUT_K(4), .MODE_X("DLATCH"), .QX_D("DI"), .QY_D("DI"), .QY_INIT(1'b1),
                 .X_OUT("QX"), .Y_OUT("ZZ"))
        u_l (.K(K), .RST_N(RST_N), .IN(IN), .DI(DI), .EC(EC), .SR(SR), .X(xo[5]), .Y(yo[5]));

    always #10 K = ~K;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // {G, F} as seen at the CLB's function outputs
    function automatic logic [1:0] fg_of(input int i);
        logic fi0, gi0, fl, gl, m;
        fi0 = (cfg[i].ffb == 1) ? mq[i][0] : (cfg[i].ffb == 2) ? mq[i][1] : IN[0];
        gi0 = (cfg[i].gfb == 1) ? mq[i][0] : (cfg[i].gfb == 2) ? mq[i][1] : IN[0];
        fl = cfg[i].finit[{IN[3:1], fi0}];
        gl = cfg[i].ginit[{IN[3:1], gi0}];
        if (cfg[i].comb != 0) begin
            m = IN[4] ? gl : fl;
            return {m, m};
        end
        return {gl, fl};
    endfunction

    function automatic logic pick(input int s, input logic [1:0] fg, input int i);
        case (s)
            0: return fg[0];
            1: return fg[1];
            2: return mq[i][0];
            default: return mq[i][1];
        endcase
    endfunction

    function automatic logic dsel(input int s, input logic [1:0] fg);
        case (s)
            0: return fg[0];
            1: return fg[1];
            default: return DI;
        endcase
    endfunction

    task automatic model_step();
        logic pe, ne, act, lvl, srv;
        logic [1:0] fg;
        logic dn [2];
        int lat;
        pe = !kp && K;
        ne = kp && !K;
        kp = K;
        for (int i = 0; i < 6; i++) begin
            fg = fg_of(i);
            dn[0] = dsel(cfg[i].qxd, fg);
            dn[1] = dsel(cfg[i].qyd, fg);
            if (!RST_N) begin
                mq[i][0] = cfg[i].qxi[0];
                mq[i][1] = cfg[i].qyi[0];
            end else begin
                for (int e = 0; e < 2; e++) begin
                    lat = (e == 0) ? cfg[i].latx : cfg[i].laty;
                    srv = (e == 0) ? cfg[i].srx[0] : cfg[i].sry[0];
                    act = (cfg[i].neg != 0) ? ne : pe;
                    lvl = (cfg[i].neg != 0) ? !K : K;
                    if (lat != 0) begin
                        if (lvl && EC) mq[i][e] = SR ? srv : dn[e];
                    end else if (act) begin
                        if (SR) mq[i][e] = srv;
                        else if (EC) mq[i][e] = dn[e];
                    end
                end
            end
        end
    endtask

    // Model follows every input/clock event; outputs compared 1ns later
    always @(K or RST_N or DI or EC or SR or IN) begin
        logic [1:0] fg;
        model_step();
        #1;
        for (int i = 0; i < 6; i++) begin
            fg = fg_of(i);
            chk($sformatf("model_x%0d", i), xo[i], pick(cfg[i].xsel, fg, i));
            chk($sformatf("model_y%0d", i), yo[i], pick(cfg[i].ysel, fg, i));
        end
    end

    task automatic pos2();
        @(posedge K); #2;
    endtask
    task automatic neg2();
        @(negedge K); #2;
    endtask
    task automatic rst_pulse();
        neg2();
        RST_N = 1'b0;
        #3;
        RST_N = 1'b1;
    endtask

    initial begin
        logic exp_cnt [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0] cin [4] = '{5'b1_0000, 5'b0_1111, 5'b1_1111, 5'b0_0000};
        logic       cex [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

        RST_N = 1'b0; EC = 1'b1;
        repeat (2) pos2();
        chk("rst_qx_b", xo[1], 1'b1);
        chk("rst_qy_a", yo[0], 1'b0);
        chk("rst_qy_l_fallback", yo[5], 1'b1);
        chk("rst_cnt_d", xo[3], 1'b0);

        neg2();
        RST_N = 1'b1; DI = 1'b0;
        pos2();
        chk("first_cap_qx", xo[1], 1'b0);
        #3; RST_N = 1'b0;
        #2; chk("midclk_rst_qx", xo[1], 1'b1);
        chk("midclk_rst_qy", yo[0], 1'b0);
        neg2(); RST_N = 1'b1;
        pos2();
        chk("post_rst_cap", xo[1], 1'b0);

        EC = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(K); #2;
            IN = 5'(i);
            #2;
            chk($sformatf("tt_%0d", i), xo[0], logic'(i == 15));
        end

        for (int i = 0; i < 4; i++) begin
            @(K); #2;
            IN = cin[i];
            #2;
            chk($sformatf("comb_x_%0d", i), xo[2], cex[i]);
            chk($sformatf("comb_y_%0d", i), yo[2], cex[i]);
        end

        rst_pulse();
        EC = 1'b1; SR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pos2();
            chk($sformatf("cnt_%0d", i), xo[3], exp_cnt[i]);
        end
        EC = 1'b0;
        pos2(); chk("cnt_hold0", xo[3], 1'b0);
        pos2(); chk("cnt_hold1", xo[3], 1'b0);

        rst_pulse();
        IN = 5'd5; SR = 1'b1; EC = 1'b0;
        pos2(); chk("sr_no_ec", yo[0], 1'b1);
        neg2(); SR = 1'b0; EC = 1'b1;
        pos2(); chk("ec_load_g", yo[0], 1'b0);
        neg2(); SR = 1'b1; EC = 1'b1;
        pos2(); chk("sr_over_ec", yo[0], 1'b1);
        neg2(); SR = 1'b0;

        rst_pulse();
        DI = 1'b1; EC = 1'b1; SR = 1'b0;
        pos2(); chk("neg_no_pos_cap", xo[4], 1'b0);
        neg2(); chk("neg_cap1", xo[4], 1'b1);
        DI = 1'b0;
        neg2(); chk("neg_cap0", xo[4], 1'b0);
        SR = 1'b1;
        neg2(); chk("neg_sr", xo[4], 1'b1);
        SR = 1'b0;

        rst_pulse();
        pos2();
        DI = 1'b1; EC = 1'b1; SR = 1'b0;
        #2; chk("lat_follow1", xo[5], 1'b1);
        #1; DI = 1'b0;
        #2; chk("lat_follow0", xo[5], 1'b0);
        #1; DI = 1'b1;
        neg2(); DI = 1'b0;
        #2; chk("lat_hold", xo[5], 1'b1);
        pos2(); EC = 1'b0;
        #1; DI = 1'b1;
        #2; chk("lat_ec_hold", xo[5], 1'b0);
        pos2(); EC = 1'b1; SR = 1'b1;
        #2; chk("lat_sr", xo[5], 1'b0);
        #1; SR = 1'b0;
        #2; chk("lat_sr_release", xo[5], 1'b1);

        repeat (2) pos2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
